// File: rtl/tlk2711_rd_dma_arb.sv
`default_nettype none
// ============================================================================
// Module   : tlk2711_rd_dma_arb
// Purpose  : Shares one tlk2711_dma read engine between NUM_CH TX lanes.
//            Round-robin command arbitration with one command in flight,
//            zero-latency routing of the returned read stream to the granted
//            lane, per-lane completion pulses and a stall watchdog that
//            aborts the transfer and drains the rest of the burst.
// Ports    : clk / rst            clock, asynchronous active-high reset
//            i_soft_rst           synchronous abort of all activity
//            i_ch_cmd_*/o_ch_cmd_ack  per-lane command request channel
//            o_cmd_req/o_cmd_data/i_cmd_ack  command port to the DMA
//            i_dma_*/o_dma_ready  read stream from the DMA
//            o_ch_valid/last/data, i_ch_ready  per-lane read stream
//            o_ch_done, o_timeout, o_busy, o_grant_id  status
// Revision : 1.0  initial release
// ============================================================================
module tlk2711_rd_dma_arb #(
    parameter int                    NUM_CH     = 4,
    parameter int                    ADDR_WIDTH = 48,
    parameter int                    DLEN_WIDTH = 16,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    TO_WIDTH   = 16,
    parameter logic [TO_WIDTH-1:0]   TO_CYCLES  = 16'd4096,
    localparam int                   c_cmd_w    = DLEN_WIDTH + ADDR_WIDTH,
    localparam int                   c_gw       = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_soft_rst,
    input  logic [NUM_CH-1:0]          i_ch_cmd_req,
    input  logic [NUM_CH*c_cmd_w-1:0]  i_ch_cmd_data,
    output logic [NUM_CH-1:0]          o_ch_cmd_ack,
    output logic                       o_cmd_req,
    output logic [c_cmd_w-1:0]         o_cmd_data,
    input  logic                       i_cmd_ack,
    input  logic                       i_dma_valid,
    input  logic                       i_dma_last,
    input  logic [DATA_WIDTH-1:0]      i_dma_data,
    output logic                       o_dma_ready,
    output logic [NUM_CH-1:0]          o_ch_valid,
    output logic                       o_ch_last,
    output logic [DATA_WIDTH-1:0]      o_ch_data,
    input  logic [NUM_CH-1:0]          i_ch_ready,
    output logic [NUM_CH-1:0]          o_ch_done,
    output logic                       o_timeout,
    output logic                       o_busy,
    output logic [c_gw-1:0]            o_grant_id
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_cmd   = 2'd1;
    localparam logic [1:0] c_st_xfer  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [c_gw:0]   c_num_ch  = (c_gw+1)'(NUM_CH);
    localparam logic [c_gw-1:0] c_last_ch = c_gw'(NUM_CH - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nx;
    logic [c_gw-1:0]         r_ptr;
    logic [c_gw-1:0]         r_grant;
    logic [c_cmd_w-1:0]      r_cmd_data;
    logic [TO_WIDTH-1:0]     r_cnt;
    logic [NUM_CH-1:0]       r_done;
    logic                    r_timeout;

    logic [2*NUM_CH-1:0]     w_req_rot;
    logic [c_gw-1:0]         w_off;
    logic [c_gw:0]           w_sum;
    logic [c_gw-1:0]         w_pick;
    logic [c_gw-1:0]         w_ptr_nx;
    logic                    w_wd_en;
    logic                    w_wd_hit;
    logic                    w_progress;
    logic                    w_to_fire;
    logic                    w_done_fire;
    logic [NUM_CH-1:0]       w_ch_cmd_ack;
    logic [NUM_CH-1:0]       w_ch_valid;
    logic                    w_dma_ready;

    // Rotate the request vector so that bit 0 corresponds to the lane at the
    // round-robin pointer; the first set bit is then the offset from ptr.
    assign w_req_rot = {i_ch_cmd_req, i_ch_cmd_req} >> r_ptr;

    always_comb begin
        w_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_off = c_gw'(j);
            end
        end
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= c_num_ch) ? c_gw'(w_sum - c_num_ch) : c_gw'(w_sum);
    end

    assign w_ptr_nx = (r_grant == c_last_ch) ? '0 : r_grant + 1'b1;

    assign w_wd_en  = (TO_CYCLES != '0);
    assign w_wd_hit = w_wd_en && (r_cnt == TO_CYCLES - 1'b1);

    always_comb begin
        w_state_nx   = r_state;
        w_ch_cmd_ack = '0;
        w_ch_valid   = '0;
        w_dma_ready  = 1'b0;
        w_progress   = 1'b0;
        w_to_fire    = 1'b0;
        w_done_fire  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (|i_ch_cmd_req) begin
                    w_state_nx = c_st_cmd;
                end
            end
            c_st_cmd: begin
                // An ack and a watchdog expiry in the same cycle: the ack wins.
                if (i_cmd_ack) begin
                    w_ch_cmd_ack[r_grant] = 1'b1;
                    w_progress            = 1'b1;
                    w_state_nx            = c_st_xfer;
                end else if (w_wd_hit) begin
                    w_to_fire  = 1'b1;
                    w_state_nx = c_st_idle;
                end
            end
            c_st_xfer: begin
                w_dma_ready         = i_ch_ready[r_grant];
                w_ch_valid[r_grant] = i_dma_valid;
                if (i_dma_valid && i_ch_ready[r_grant]) begin
                    w_progress = 1'b1;
                    if (i_dma_last) begin
                        w_done_fire = 1'b1;
                        w_state_nx  = c_st_idle;
                    end
                end else if (w_wd_hit) begin
                    w_to_fire  = 1'b1;
                    w_state_nx = c_st_drain;
                end
            end
            default: begin
                // Drain: sink the remainder of an aborted burst.
                w_dma_ready = 1'b1;
                if (i_dma_valid && i_dma_last) begin
                    w_state_nx = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_cmd_data <= '0;
            r_cnt      <= '0;
            r_done     <= '0;
            r_timeout  <= 1'b0;
        end else if (i_soft_rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_cmd_data <= '0;
            r_cnt      <= '0;
            r_done     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_timeout <= w_to_fire;
            r_done    <= '0;
            if (w_done_fire) begin
                r_done[r_grant] <= 1'b1;
            end
            if (r_state == c_st_idle && (|i_ch_cmd_req)) begin
                r_grant    <= w_pick;
                r_cmd_data <= i_ch_cmd_data[int'(w_pick)*c_cmd_w +: c_cmd_w];
            end
            // The pointer moves past the granted lane once its command is
            // accepted, and also on an abort so a stalled lane loses priority.
            if ((r_state == c_st_cmd && i_cmd_ack) || w_to_fire) begin
                r_ptr <= w_ptr_nx;
            end
            // Counter restarts on every state change and every bit of progress.
            if (!w_wd_en || w_progress || (w_state_nx != r_state)) begin
                r_cnt <= '0;
            end else if (r_state == c_st_cmd || r_state == c_st_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_ch_cmd_ack = w_ch_cmd_ack;
    assign o_cmd_req    = (r_state == c_st_cmd);
    assign o_cmd_data   = r_cmd_data;
    assign o_dma_ready  = w_dma_ready;
    assign o_ch_valid   = w_ch_valid;
    // Broadcast data is forced to zero outside XFER so idle outputs stay quiet.
    assign o_ch_last    = (r_state == c_st_xfer) ? i_dma_last : 1'b0;
    assign o_ch_data    = (r_state == c_st_xfer) ? i_dma_data : '0;
    assign o_ch_done    = r_done;
    assign o_timeout    = r_timeout;
    assign o_busy       = (r_state != c_st_idle);
    assign o_grant_id   = r_grant;

endmodule
`default_nettype wire
